// File: rtl/arith_pkg.sv
// Shared arithmetic package: divider FSM states, default widths and
// the quotient value reported on divide-by-zero.
package arith_pkg;

    localparam int unsigned DW_DEF = 8;
    localparam int unsigned VW_DEF = 4;

    // Every quotient bit is this value when the divisor is zero.
    localparam logic DBZ_QUOT_BIT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in the next dividend bit, then
// subtract the divisor only when the trial value is large enough.
module div_restore_step #(
    parameter int unsigned VW = 4
) (
    input  logic [VW:0]   r_i,
    input  logic          q_msb_i,
    input  logic [VW-1:0] d_i,
    output logic [VW:0]   r_nxt_c,
    output logic          q_bit_c
);

    localparam int unsigned TW = VW + 2;

    logic [TW-1:0] t_c;
    logic [TW-1:0] d_ext_c;

    // Trial value is kept one bit wider than R so the compare is exact.
    always_comb begin
        t_c     = {r_i, q_msb_i};
        d_ext_c = TW'(d_i);
        q_bit_c = (t_c >= d_ext_c);
        if (q_bit_c) begin
            r_nxt_c = (VW + 1)'(t_c - d_ext_c);
        end else begin
            r_nxt_c = (VW + 1)'(t_c);
        end
    end

endmodule

// File: rtl/div8by4_seq.sv
// Sequential restoring divider behind a start/done handshake; retires
// one quotient bit per clock and holds results until the next operation.
module div8by4_seq
    import arith_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dbz
);

    localparam int unsigned CW = $clog2(DW + 1);

    state_e        state_q, state_d;
    logic [DW-1:0] q_q, q_d;
    logic [VW:0]   r_q, r_d;
    logic [VW-1:0] d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW-1:0] quotient_q, quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic          dbz_q, dbz_d;

    logic [VW:0]   step_r_c;
    logic          step_bit_c;
    logic [DW-1:0] q_shift_c;

    div_restore_step #(
        .VW (VW)
    ) u_step (
        .r_i     (r_q),
        .q_msb_i (q_q[DW-1]),
        .d_i     (d_q),
        .r_nxt_c (step_r_c),
        .q_bit_c (step_bit_c)
    );

    assign q_shift_c = {q_q[DW-2:0], step_bit_c};

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        r_d         = r_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        q_d     = dividend;
                        r_d     = '0;
                        d_d     = divisor;
                        cnt_d   = CW'(DW);
                        state_d = RUN;
                    end else begin
                        // Zero divisor skips RUN and reports at once.
                        q_d         = {DW{DBZ_QUOT_BIT}};
                        r_d         = '0;
                        state_d     = DONE;
                        done_d      = 1'b1;
                        quotient_d  = {DW{DBZ_QUOT_BIT}};
                        remainder_d = '0;
                        dbz_d       = 1'b1;
                    end
                end
            end
            RUN: begin
                q_d   = q_shift_c;
                r_d   = step_r_c;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    quotient_d  = q_shift_c;
                    remainder_d = step_r_c[VW-1:0];
                    dbz_d       = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            q_q         <= '0;
            r_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            r_q         <= r_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_div8by4_seq.sv
// Directed bench for div8by4_seq: latency, results, dbz, ignored start,
// mid-run reset, multiply round trip and a random invariant sweep.
module tb_div8by4_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       dbz;

    int n_cmp;
    int n_bad;

    div8by4_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts one division in the cycle after the current negedge and
    // follows it to the done pulse (cycle count bounded).
    task automatic run_div(input string tag, input logic [7:0] a, input logic [3:0] b,
                           input logic [7:0] eq, input logic [3:0] er, input logic ed,
                           input int el);
        int lat;
        int busy_low;
        bit got;
        @(negedge clk);
        chk({tag, ".ready"}, 32'(ready), 32'd1);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        lat      = 0;
        busy_low = 0;
        got      = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy !== 1'b1) busy_low++;
            if (done === 1'b1) got = 1'b1;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(el));
        chk({tag, ".busy"}, 32'(busy_low), 32'd0);
        chk({tag, ".quotient"}, 32'(quotient), 32'(eq));
        chk({tag, ".remainder"}, 32'(remainder), 32'(er));
        chk({tag, ".dbz"}, 32'(dbz), 32'(ed));
    endtask

    initial begin
        int lat;
        bit got;
        bit saw_done;
        logic [7:0] a;
        logic [3:0] b;

        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 4'd0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.ready", 32'(ready), 32'd1);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.quotient", 32'(quotient), 32'd0);
        chk("reset.remainder", 32'(remainder), 32'd0);
        chk("reset.dbz", 32'(dbz), 32'd0);

        run_div("d200_7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 9);
        @(negedge clk);
        chk("d200_7.done_single", 32'(done), 32'd0);
        chk("d200_7.ready_after", 32'(ready), 32'd1);
        chk("d200_7.held_q", 32'(quotient), 32'd28);

        // Start pulse at cycle 4 of an operation must be ignored.
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        lat      = 0;
        got      = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 4) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 4'd5;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) got = 1'b1;
        end
        chk("ign.latency", 32'(lat), 32'd9);
        chk("ign.quotient", 32'(quotient), 32'd28);
        chk("ign.remainder", 32'(remainder), 32'd4);
        run_div("b2b_50_5", 8'd50, 4'd5, 8'd10, 4'd0, 1'b0, 9);

        run_div("dbz_100", 8'd100, 4'd0, 8'd255, 4'd0, 1'b1, 1);
        run_div("d255_15", 8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 9);
        run_div("d5_9", 8'd5, 4'd9, 8'd0, 4'd5, 1'b0, 9);
        run_div("d255_1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 9);
        run_div("d14_15", 8'd14, 4'd15, 8'd0, 4'd14, 1'b0, 9);
        run_div("dbz_0", 8'd0, 4'd0, 8'd255, 4'd0, 1'b1, 1);

        // Reset asserted at cycle 5 of an operation discards it.
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid.ready", 32'(ready), 32'd1);
        chk("rst_mid.busy", 32'(busy), 32'd0);
        chk("rst_mid.quotient", 32'(quotient), 32'd0);
        chk("rst_mid.remainder", 32'(remainder), 32'd0);
        chk("rst_mid.dbz", 32'(dbz), 32'd0);
        saw_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("rst_mid.no_done", 32'(saw_done), 32'd0);

        // Undo every 4x4 product by its second factor.
        for (int i = 0; i < 16; i++) begin
            for (int j = 1; j < 16; j++) begin
                a = 8'(i * j);
                b = 4'(j);
                run_div($sformatf("rt_%0d_%0d", i, j), a, b, 8'(i), 4'd0, 1'b0, 9);
            end
        end

        for (int k = 0; k < 60; k++) begin
            a = 8'($urandom_range(0, 255));
            b = 4'($urandom_range(1, 15));
            run_div($sformatf("rnd_%0d_%0d", a, b), a, b, 8'(a / b), 4'(a % b), 1'b0, 9);
            chk("rnd.invariant", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
